safe_lock_ctrl: RTL and testbench

Lock-policy controller directly downstream of the serial code detector. It consumes the detector's one-cycle verdict (`code_val`/`code_ok`) and drives the bolt (`unlock`). It counts consecutive failed attempts and enforces a timed lockout after `MAX_FAILS` failures. It also gates the upstream serial entry through `ser_en`, so codes are only accepted while locked.

---
 rtl/safe_lock_pkg.sv | 24 ++
 rtl/safe_lock_ctrl_if.sv | 24 ++
 rtl/safe_lock_timer.sv | 26 ++
 rtl/safe_lock_ctrl.sv | 115 +++++++++++
 tb/tb_safe_lock_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/safe_lock_pkg.sv
// Shared types and defaults for the lock-policy controller.
// Holds the FSM state enum, default parameter values and small sizing helpers.
package safe_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_e;

    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1000;
    localparam int DEF_OPEN_CYCLES    = 500;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/safe_lock_ctrl_if.sv
// Verdict, door and bolt signals between detector/door side and the lock controller.
// master = environment side (drives verdicts and sensors), slave = controller.
interface safe_lock_ctrl_if #(
    parameter int FCW = 2
);
    logic           code_val;
    logic           code_ok;
    logic           door_closed;
    logic           relock;
    logic           unlock;
    logic           locked_out;
    logic           ser_en;
    logic [FCW-1:0] fail_cnt;

    modport master (
        output code_val, code_ok, door_closed, relock,
        input  unlock, locked_out, ser_en, fail_cnt
    );

    modport slave (
        input  code_val, code_ok, door_closed, relock,
        output unlock, locked_out, ser_en, fail_cnt
    );
endinterface

// File: rtl/safe_lock_timer.sv
// Loadable down-counter shared by lockout and open-door timing.
// Latency: load/decrement visible next cycle; no backpressure, holds at zero.
module safe_lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/safe_lock_ctrl.sv
// Lock policy: consumes detector verdicts, drives bolt, counts fails, timed lockout.
// Latency: verdict to output 1 cycle; outputs decoded from state register only.
// No backpressure; ser_en gates upstream entry. Optional: SAFE_LOCK_AUTO_RELOCK_EN.
module safe_lock_ctrl
    import safe_lock_pkg::*;
#(
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES
) (
    input  logic             clk,
    input  logic             rstn,
    safe_lock_ctrl_if.slave  lk
);
    localparam int FCW  = $clog2(MAX_FAILS + 1);
    localparam int TMAX = max_i(LOCKOUT_CYCLES, OPEN_CYCLES);
    localparam int TW   = cnt_w(TMAX);

    localparam logic [FCW-1:0] FAIL_SAT  = FCW'(MAX_FAILS);
    localparam logic [FCW-1:0] FAIL_LAST = FCW'(MAX_FAILS - 1);
    localparam logic [TW-1:0]  LOCK_LD   = TW'(LOCKOUT_CYCLES - 1);
`ifdef SAFE_LOCK_AUTO_RELOCK_EN
    localparam logic [TW-1:0]  OPEN_LD   = TW'(OPEN_CYCLES - 1);
`endif

    lock_state_e    state_q, state_d;
    logic [FCW-1:0] fail_q, fail_d;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_en;
    logic           tmr_zero;

    safe_lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LOCKED;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state_q)
            LOCKED: begin
                if (lk.code_val) begin
                    if (lk.code_ok) begin
                        state_d = OPEN;
                        fail_d  = '0;
`ifdef SAFE_LOCK_AUTO_RELOCK_EN
                        // Arm the closed-door window on entry so a door that is
                        // already shut still waits the full OPEN_CYCLES.
                        tmr_load = 1'b1;
                        tmr_val  = OPEN_LD;
`endif
                    end else if (fail_q >= FAIL_LAST) begin
                        state_d  = LOCKOUT;
                        fail_d   = FAIL_SAT;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LD;
                    end else begin
                        fail_d = fail_q + FCW'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            OPEN: begin
`ifdef SAFE_LOCK_AUTO_RELOCK_EN
                if (!lk.door_closed) begin
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LD;
                end else if (lk.relock || tmr_zero) begin
                    state_d = LOCKED;
                end else begin
                    tmr_en = 1'b1;
                end
`else
                if (lk.relock && lk.door_closed) begin
                    state_d = LOCKED;
                end
`endif
            end
            default: begin
                state_d = LOCKED;
                fail_d  = '0;
            end
        endcase
    end

    assign lk.unlock     = (state_q == OPEN);
    assign lk.locked_out = (state_q == LOCKOUT);
    assign lk.ser_en     = (state_q == LOCKED);
    assign lk.fail_cnt   = fail_q;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Scoreboarded bench: driver feeds a cycle-level policy model and queues expected outputs,
// monitor pops and compares one entry per clock.
module tb_safe_lock_ctrl;
    localparam int MF = 3;
    localparam int LC = 8;
    localparam int OC = 4;

    localparam int M_LOCKED  = 0;
    localparam int M_OPEN    = 1;
    localparam int M_LOCKOUT = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    safe_lock_ctrl_if #(.FCW(2)) lk();

    safe_lock_ctrl #(
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC),
        .OPEN_CYCLES    (OC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .lk   (lk)
    );

    typedef struct packed {
        logic       unlock;
        logic       locked_out;
        logic       ser_en;
        logic [1:0] fc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Policy model: mode, consecutive fails, lockout cycles remaining, closed-door run.
    int m_mode, m_fails, m_left, m_run;

    function automatic exp_t m_out();
        exp_t e;
        e.unlock     = (m_mode == M_OPEN);
        e.locked_out = (m_mode == M_LOCKOUT);
        e.ser_en     = (m_mode == M_LOCKED);
        e.fc         = 2'(m_fails);
        return e;
    endfunction

    function automatic void m_reset();
        m_mode  = M_LOCKED;
        m_fails = 0;
        m_left  = 0;
        m_run   = 0;
    endfunction

    function automatic void m_step(input logic v, input logic ok, input logic dc, input logic rl);
        if (m_mode == M_LOCKED) begin
            if (v && ok) begin
                m_mode  = M_OPEN;
                m_fails = 0;
                m_run   = 0;
            end else if (v) begin
                m_fails = m_fails + 1;
                if (m_fails == MF) begin
                    m_mode = M_LOCKOUT;
                    m_left = LC;
                end
            end
        end else if (m_mode == M_LOCKOUT) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_mode  = M_LOCKED;
                m_fails = 0;
            end
        end else begin
`ifdef SAFE_LOCK_AUTO_RELOCK_EN
            m_run = dc ? m_run + 1 : 0;
            if ((rl && dc) || m_run >= OC) m_mode = M_LOCKED;
`else
            if (rl && dc) m_mode = M_LOCKED;
`endif
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic ok, input logic dc, input logic rl);
        @(negedge clk);
        rstn           = 1'b1;
        lk.code_val    = v;
        lk.code_ok     = ok;
        lk.door_closed = dc;
        lk.relock      = rl;
        m_step(v, ok, dc, rl);
        expq.push_back(m_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rstn           = 1'b0;
        lk.code_val    = 1'b0;
        lk.code_ok     = 1'b0;
        lk.door_closed = 1'b1;
        lk.relock      = 1'b0;
        #1;
        m_reset();
        e = m_out();
        chk("rst_unlock",     lk.unlock,     e.unlock);
        chk("rst_locked_out", lk.locked_out, e.locked_out);
        chk("rst_ser_en",     lk.ser_en,     e.ser_en);
        chk("rst_fail_cnt",   lk.fail_cnt,   e.fc);
        expq.push_back(e);
    endtask

    // Monitor: one expected entry per clock once the driver has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("unlock",     lk.unlock,     e.unlock);
                chk("locked_out", lk.locked_out, e.locked_out);
                chk("ser_en",     lk.ser_en,     e.ser_en);
                chk("fail_cnt",   lk.fail_cnt,   e.fc);
            end
        end
    end

    initial begin
        lk.code_val    = 1'b0;
        lk.code_ok     = 1'b0;
        lk.door_closed = 1'b1;
        lk.relock      = 1'b0;
        m_reset();

        do_reset();
        idle(2);

        // Correct code opens, then manual relock with door shut.
        cyc(1, 1, 1, 0);
        idle(1);
        cyc(0, 0, 1, 1);
        idle(1);

        // Wrong, wrong, right: no lockout.
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 1, 1);
        idle(1);

        // Three wrong: lockout, strobes during lockout ignored.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1'($urandom), 1, 0);
        idle(3);

        // Relock with door open is dropped.
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        idle(2);

        // Closed 3, open 1, closed 4: auto-relock only after the 4-run (macro build).
        cyc(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 1, 1);
        idle(1);

        // Reset mid-lockout.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        idle(3);
        do_reset();
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(2) == 0), 1'($urandom),
                    1'($urandom_range(3) != 0), 1'($urandom_range(5) == 0));
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
